// File: rtl/ext_ins_mem_pkg.sv
// Shared definitions for the external instruction memory server: word width,
// the NOP returned on error responses and the server FSM state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- harmless filler returned with an error response
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        RESP = 2'd3
    } ext_mem_state_e;

endpackage

// File: rtl/ext_ins_mem_if.sv
// External instruction port between the core (master) and the memory server
// (slave), plus the host preload write port that rides alongside it.
interface ext_ins_mem_if;
    import riscv_pkg::*;

    // fetch request / response
    logic            exIns_ren;
    logic [XLEN-1:0] exIns_addr;
    logic            exIns_valid;
    logic [XLEN-1:0] exIns_in;
    logic            exIns_err;
    logic            busy;

    // preload write port
    logic            ld_we;
    logic [XLEN-1:0] ld_addr;
    logic [XLEN-1:0] ld_data;

    modport master (
        output exIns_ren, exIns_addr, ld_we, ld_addr, ld_data,
        input  exIns_valid, exIns_in, exIns_err, busy
    );

    modport slave (
        input  exIns_ren, exIns_addr, ld_we, ld_addr, ld_data,
        output exIns_valid, exIns_in, exIns_err, busy
    );

endinterface

// File: rtl/ext_ins_mem_sram.sv
// Simple dual-port instruction array: one write port, one registered read
// port. No reset on the array so it maps onto block RAM; the array is named
// mem so it can be reached hierarchically for preload.
module ins_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS),
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH_WORDS];
    logic [DW-1:0] rdata_q;

    // write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // registered read port; data holds when no read is issued
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_ins_mem.sv
// External instruction memory server. Accepts one fetch at a time, waits
// WAIT_CYCLES to model off-chip latency, reads the array and returns the word
// with a one-cycle exIns_valid pulse. Misaligned or out-of-range fetches get
// NOP_WORD with exIns_err. A preload write port fills the array and wins over
// a concurrent fetch read, which is then retried one cycle later.
module ext_ins_mem
    import riscv_pkg::*;
#(
    parameter int              DEPTH_WORDS = 1024,
    parameter int              WAIT_CYCLES = 2,
    parameter logic [XLEN-1:0] NOP_WORD    = NOP_INSN
) (
    input  logic clk,
    input  logic nrst,
    ext_ins_mem_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_READ = READ;
    localparam logic [1:0] S_RESP = RESP;

    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [XLEN-3:0] DEPTH_IDX = (XLEN-2)'(DEPTH_WORDS);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic [AW-1:0]   idx_q,   idx_d;
    logic            err_q,   err_d;
    logic [XLEN-1:0] hold_q,  hold_d;

    logic            req_err;
    logic            ld_in_range;
    logic            sram_re;
    logic [XLEN-1:0] sram_rdata;
    logic [XLEN-1:0] resp_word;
    logic            resp_now;
    logic            ld_addr_unused;

    // Byte-offset bits of the preload address carry no information.
    assign ld_addr_unused = ^bus.ld_addr[1:0];

    // Fetch is bad when not word aligned or its word index lies past the array.
    assign req_err = (bus.exIns_addr[1:0] != 2'b00) ||
                     (bus.exIns_addr[XLEN-1:2] >= DEPTH_IDX);

    // Out-of-range preload writes are silently dropped.
    assign ld_in_range = bus.ld_we && (bus.ld_addr[XLEN-1:2] < DEPTH_IDX);

    // Read only in READ, for a live good request, and never alongside a preload.
    assign sram_re = (state_q == S_READ) && bus.exIns_ren && !err_q && !bus.ld_we;

    ins_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW),
        .DW          (XLEN)
    ) u_sram (
        .clk     (clk),
        .we_i    (ld_in_range),
        .waddr_i (bus.ld_addr[AW+1:2]),
        .wdata_i (bus.ld_data),
        .re_i    (sram_re),
        .raddr_i (idx_q),
        .rdata_o (sram_rdata)
    );

    assign resp_now  = (state_q == S_RESP);
    assign resp_word = err_q ? NOP_WORD : sram_rdata;

    assign bus.exIns_valid = resp_now;
    assign bus.exIns_err   = resp_now && err_q;
    assign bus.exIns_in    = resp_now ? resp_word : hold_q;
    assign bus.busy        = (state_q != S_IDLE);

    // Next-state logic for the accept / wait / read / respond sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (bus.exIns_ren) begin
                    idx_d   = bus.exIns_addr[AW+1:2];
                    err_d   = req_err;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_READ : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.exIns_ren) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_READ;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            S_READ: begin
                // A preload in this cycle blocks the read; stay and retry.
                if (!bus.exIns_ren) begin
                    state_d = S_IDLE;
                end else if (!bus.ld_we) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                hold_d  = resp_word;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, latched request and last-response registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_ext_ins_mem.sv
// Bench for ext_ins_mem: preloads the array through the load port, runs a
// table of single fetches, then hand-written back-to-back, abort, preload
// collision and mid-transaction reset sequences. Expected responses go into a
// queue when a request is driven and are checked when exIns_valid pulses.
module tb_ext_ins_mem;
    import riscv_pkg::*;

    localparam int DEPTH = 1024;
    localparam int W     = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    ext_ins_mem_if bus();

    ext_ins_mem #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W),
        .NOP_WORD    (NOP)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;

    logic [31:0] pre [8] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
                             32'h0050_0093, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008};
    vec_t vt [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // response monitor: every valid pulse must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.exIns_valid === 1'b1) begin
                pulses++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got pulse data=%08h at cycle %0d expected none",
                             bus.exIns_in, cyc);
                end else begin
                    e = sb.pop_front();
                    $display("resp cyc=%0d data=%08h err=%0b", cyc, bus.exIns_in, bus.exIns_err);
                    chk("resp_data", bus.exIns_in, e.data);
                    chk("resp_err", 32'(bus.exIns_err), 32'(e.err));
                    chk("resp_latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic e, input int lat);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.lat  = lat;
        x.t0   = cyc;
        sb.push_back(x);
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic e, input int lat);
        @(posedge clk);
        #1;
        bus.exIns_addr = a;
        bus.exIns_ren  = 1'b1;
        push_exp(d, e, lat);
        $display("req  cyc=%0d addr=%08h", cyc, a);
    endtask

    task automatic wait_valid(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.exIns_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no valid in 40 cycles expected a pulse", name);
        end
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.ld_we   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        @(posedge clk);
        #1;
        bus.ld_we = 1'b0;
        $display("load cyc=%0d addr=%08h data=%08h", cyc, a, d);
    endtask

    initial begin
        int p0;
        bus.exIns_ren  = 1'b0;
        bus.exIns_addr = '0;
        bus.ld_we      = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_data    = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.exIns_valid), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_in",    bus.exIns_in, 32'd0);
        chk("rst_err",   32'(bus.exIns_err), 32'd0);
        nrst = 1'b1;

        // preload; the 0x1000 write is out of range and must not alias onto word 0
        for (int i = 0; i < 8; i++) ld(32'(i * 4), pre[i]);
        ld(32'h0000_0FFC, 32'h1234_ABCD);
        ld(32'h0000_1000, 32'hBAD0_BAD0);

        vt[0] = '{32'h0000_0010, 32'h0050_0093, 1'b0};
        vt[1] = '{32'h0000_0000, 32'h1111_0001, 1'b0};
        vt[2] = '{32'h0000_0012, NOP,           1'b1};
        vt[3] = '{32'h0000_1000, NOP,           1'b1};
        vt[4] = '{32'h0000_0FFC, 32'h1234_ABCD, 1'b0};
        vt[5] = '{32'h0000_0003, NOP,           1'b1};
        vt[6] = '{32'hFFFF_FFF0, NOP,           1'b1};
        vt[7] = '{32'h0000_001C, 32'h8888_0008, 1'b0};

        // single fetches; after each, the IDLE cycle must show not-busy and held data
        for (int i = 0; i < 8; i++) begin
            req(vt[i].addr, vt[i].data, vt[i].err, W + 2);
            wait_valid("table");
            bus.exIns_ren = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("hold_in", bus.exIns_in, vt[i].data);
        end

        // back-to-back: ren held high across three words
        req(32'h0, pre[0], 1'b0, W + 2);
        for (int k = 1; k < 3; k++) begin
            wait_valid("b2b");
            bus.exIns_addr = 32'(k * 4);
            push_exp(pre[k], 1'b0, W + 3);
            @(negedge clk);
            chk("b2b_gap_busy", 32'(bus.busy), 32'd0);
        end
        wait_valid("b2b");
        bus.exIns_ren = 1'b0;

        // abort in the second WAIT cycle
        p0 = pulses;
        @(posedge clk);
        #1;
        bus.exIns_addr = 32'h4;
        bus.exIns_ren  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort_busy_wait", 32'(bus.busy), 32'd1);
        bus.exIns_ren = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_pulse", 32'(pulses), 32'(p0));
        chk("abort_idle", 32'(bus.busy), 32'd0);
        req(32'h0, pre[0], 1'b0, W + 2);
        wait_valid("after_abort");
        bus.exIns_ren = 1'b0;

        // preload collides with READ of the same word: one extra cycle, new data
        req(32'h10, 32'hDEAD_BEEF, 1'b0, W + 3);
        fork
            wait_valid("collide");
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.ld_we   = 1'b1;
                bus.ld_addr = 32'h10;
                bus.ld_data = 32'hDEAD_BEEF;
                @(posedge clk);
                #1;
                bus.ld_we = 1'b0;
            end
        join
        bus.exIns_ren = 1'b0;

        // reset pulse during WAIT clears outputs at once and drops the transaction
        p0 = pulses;
        @(posedge clk);
        #1;
        bus.exIns_addr = 32'h0;
        bus.exIns_ren  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.exIns_valid), 32'd0);
        chk("mid_rst_busy",  32'(bus.busy), 32'd0);
        chk("mid_rst_in",    bus.exIns_in, 32'd0);
        chk("mid_rst_err",   32'(bus.exIns_err), 32'd0);
        bus.exIns_ren = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_pulse", 32'(pulses), 32'(p0));

        // array contents survive reset
        req(32'h10, 32'hDEAD_BEEF, 1'b0, W + 2);
        wait_valid("after_rst");
        bus.exIns_ren = 1'b0;
        repeat (3) @(posedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
